uart_cmd_packetizer: RTL and testbench



---
 rtl/uart_cmd_packetizer.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_cmd_packetizer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_packetizer.sv
// Serialises one parallel command request into the UART command byte stream
// (opcode, optional channel, payload LSB first) over a tx_start/tx_done handshake.
module uart_cmd_packetizer #(
  parameter int unsigned OUTPUT_NUM     = 16,
  parameter logic [7:0]  CMD_DATA       = 8'h01,
  parameter logic [7:0]  CMD_CTRL       = 8'h02,
  parameter logic [7:0]  CMD_FREQ       = 8'h03,
  parameter logic [7:0]  CMD_PERIOD     = 8'h04,
  parameter logic [7:0]  CMD_REPEAT     = 8'h05,
  parameter int unsigned GAP_CYCLES     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_cmd_i,
  input  logic [7:0]  req_channel_i,
  input  logic [31:0] req_payload_i,
  output logic        tx_start_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_done_tick_i,
  output logic        busy_o,
  output logic        done_tick_o,
  output logic        err_tick_o
);

  localparam int unsigned CNT_MAX  = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W    = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam int unsigned TO_LAST  = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

  localparam logic [2:0] K_DATA   = 3'd0;
  localparam logic [2:0] K_CTRL   = 3'd1;
  localparam logic [2:0] K_FREQ   = 3'd2;
  localparam logic [2:0] K_PERIOD = 3'd3;
  localparam logic [2:0] K_REPEAT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         cmd_q, cmd_d;
  logic [7:0]         ch_q, ch_d;
  logic [31:0]        pay_q, pay_d;
  logic [2:0]         len_q, len_d;
  logic [2:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               err_q, err_d;
  logic               req_ok;

  function automatic logic [7:0] frame_byte(input logic [2:0] cmd, input logic [7:0] ch,
                                            input logic [31:0] pay, input logic [2:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (cmd)
      K_DATA: begin
        case (idx)
          3'd0:    b = CMD_DATA;
          3'd1:    b = ch;
          3'd2:    b = pay[7:0];
          3'd3:    b = pay[15:8];
          3'd4:    b = pay[23:16];
          default: b = pay[31:24];
        endcase
      end
      K_CTRL: begin
        case (idx)
          3'd0:    b = CMD_CTRL;
          3'd1:    b = ch;
          default: b = {5'h0, pay[2:0]};
        endcase
      end
      K_FREQ: begin
        case (idx)
          3'd0:    b = CMD_FREQ;
          3'd1:    b = pay[7:0];
          3'd2:    b = pay[15:8];
          3'd3:    b = pay[23:16];
          default: b = pay[31:24];
        endcase
      end
      K_PERIOD: begin
        case (idx)
          3'd0:    b = CMD_PERIOD;
          3'd1:    b = pay[7:0];
          default: b = pay[15:8];
        endcase
      end
      K_REPEAT: begin
        case (idx)
          3'd0:    b = CMD_REPEAT;
          3'd1:    b = ch;
          default: b = pay[7:0];
        endcase
      end
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [2:0] frame_len(input logic [2:0] cmd);
    logic [2:0] n;
    case (cmd)
      K_DATA:   n = 3'd6;
      K_CTRL:   n = 3'd3;
      K_FREQ:   n = 3'd5;
      K_PERIOD: n = 3'd3;
      K_REPEAT: n = 3'd3;
      default:  n = 3'd0;
    endcase
    return n;
  endfunction

  // Only DATA/CTRL/REPEAT carry a channel byte, so only they are range-checked.
  always_comb begin
    req_ok = 1'b0;
    case (req_cmd_i)
      K_FREQ, K_PERIOD:         req_ok = 1'b1;
      K_DATA, K_CTRL, K_REPEAT: req_ok = (32'(req_channel_i) < OUTPUT_NUM);
      default:                  req_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    ch_d      = ch_q;
    pay_d     = pay_q;
    len_d     = len_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (req_valid_i) begin
          if (req_ok) begin
            cmd_d     = req_cmd_i;
            ch_d      = req_channel_i;
            pay_d     = req_payload_i;
            len_d     = frame_len(req_cmd_i);
            idx_d     = 3'd0;
            tx_data_d = frame_byte(req_cmd_i, req_channel_i, req_payload_i, 3'd0);
            state_d   = S_START;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_START: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (tx_done_tick_i) begin
          idx_d = idx_q + 3'd1;
          if (idx_d == len_q) begin
            state_d = S_DONE;
          end else if (GAP_CYCLES == 0) begin
            state_d   = S_START;
            tx_data_d = frame_byte(cmd_q, ch_q, pay_q, idx_d);
          end else begin
            state_d = S_GAP;
            cnt_d   = '0;
          end
        end else if (cnt_q == CNT_W'(TO_LAST)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        // idx_q was already advanced when the previous byte completed.
        if (cnt_q == CNT_W'(GAP_LAST)) begin
          state_d   = S_START;
          tx_data_d = frame_byte(cmd_q, ch_q, pay_q, idx_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cmd_q     <= 3'd0;
      ch_q      <= 8'h00;
      pay_q     <= 32'h0;
      len_q     <= 3'd0;
      idx_q     <= 3'd0;
      cnt_q     <= '0;
      tx_data_q <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      ch_q      <= ch_d;
      pay_q     <= pay_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      err_q     <= err_d;
    end
  end

  assign req_ready_o = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy_o      = !((state_q == S_IDLE) || (state_q == S_DONE));
  assign tx_start_o  = (state_q == S_START);
  assign done_tick_o = (state_q == S_DONE);
  assign err_tick_o  = err_q;
  assign tx_data_o   = tx_data_q;

endmodule

// File: tb/tb_uart_cmd_packetizer.sv
// Bench for uart_cmd_packetizer: two instances (no gap / 3-cycle gap), a TX responder,
// a frame model built from the command table, and a negedge monitor with an expected queue.
module tb_uart_cmd_packetizer;
  localparam int TO   = 50;
  localparam int GAP1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  valid;
  logic [2:0]  cmd;
  logic [7:0]  ch;
  logic [31:0] pay;
  logic [1:0]  done_in, spur, spur_drv;
  logic [1:0]  ready, start, busy, dtick, etick;
  logic [7:0]  data [2];

  uart_cmd_packetizer #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(TO)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid[0]), .req_ready_o(ready[0]),
    .req_cmd_i(cmd), .req_channel_i(ch), .req_payload_i(pay),
    .tx_start_o(start[0]), .tx_data_o(data[0]),
    .tx_done_tick_i(done_in[0] | spur[0] | spur_drv[0]),
    .busy_o(busy[0]), .done_tick_o(dtick[0]), .err_tick_o(etick[0]));

  uart_cmd_packetizer #(.GAP_CYCLES(GAP1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid[1]), .req_ready_o(ready[1]),
    .req_cmd_i(cmd), .req_channel_i(ch), .req_payload_i(pay),
    .tx_start_o(start[1]), .tx_data_o(data[1]),
    .tx_done_tick_i(done_in[1] | spur[1] | spur_drv[1]),
    .busy_o(busy[1]), .done_tick_o(dtick[1]), .err_tick_o(etick[1]));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cur   = 0;
  logic [7:0] exp_q[$];
  bit in_frame = 0, first_pending = 0, spur_gap = 0;
  int exp_start_cyc = 0, last_done_cyc = -1, last_start_cyc = 0;
  int done_cnt = 0, err_cnt = 0, err_cyc = 0;
  int resp_delay = 10, resp_idx = 0, withhold = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected frame straight from the command table; returns 0 for a rejected request.
  function automatic bit model(input logic [2:0] c, input logic [7:0] h, input logic [31:0] p);
    logic [7:0] op;
    int nb;
    bit has_ch;
    case (c)
      3'd0: begin op = 8'h01; has_ch = 1; nb = 4; end
      3'd1: begin op = 8'h02; has_ch = 1; nb = 0; end
      3'd2: begin op = 8'h03; has_ch = 0; nb = 4; end
      3'd3: begin op = 8'h04; has_ch = 0; nb = 2; end
      3'd4: begin op = 8'h05; has_ch = 1; nb = 1; end
      default: return 0;
    endcase
    if (has_ch && h >= 8'd16) return 0;
    exp_q.push_back(op);
    if (has_ch) exp_q.push_back(h);
    if (c == 3'd1) exp_q.push_back({5'h0, p[2:0]});
    for (int i = 0; i < nb; i++) exp_q.push_back(p[8*i +: 8]);
    return 1;
  endfunction

  // TX responder: tx_done resp_delay cycles after each start, optionally withholding one byte.
  initial begin
    int cnt;
    cnt = 0;
    done_in = '0;
    spur = '0;
    forever begin
      step();
      spur = '0;
      if (spur_gap && done_in[cur]) spur[cur] = 1'b1;
      done_in = '0;
      if (start[cur]) begin
        if (resp_idx != withhold) cnt = resp_delay;
        resp_idx++;
      end else if (!busy[cur]) begin
        cnt = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) done_in[cur] = 1'b1;
      end
    end
  end

  // Monitor: sampled mid-cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (start[1-cur]) check_val("idle_inst_start", 32'(start[1-cur]), 32'd0);
        if (start[cur]) begin
          last_start_cyc = cyc;
          if (exp_q.size() == 0) check_val("unexpected_start", 32'd1, 32'd0);
          else check_val("byte", 32'(data[cur]), 32'(exp_q.pop_front()));
          if (first_pending) begin
            check_val("start_latency", 32'(cyc), 32'(exp_start_cyc));
            first_pending = 0;
          end else if (last_done_cyc >= 0) begin
            check_val("gap", 32'(cyc - last_done_cyc), 32'((cur == 0 ? 0 : GAP1) + 1));
          end
        end
        if (done_in[cur]) last_done_cyc = cyc;
        if (in_frame && !dtick[cur] && !etick[cur]) begin
          check_val("ready_in_frame", 32'(ready[cur]), 32'd0);
          check_val("busy_in_frame", 32'(busy[cur]), 32'd1);
        end
        if (dtick[cur]) begin
          check_val("done_expected", 32'(in_frame), 32'd1);
          check_val("done_bytes_left", 32'(exp_q.size()), 32'd0);
          check_val("done_ready", 32'(ready[cur]), 32'd1);
          check_val("done_busy", 32'(busy[cur]), 32'd0);
          in_frame = 0;
          done_cnt++;
        end
        if (etick[cur]) begin
          err_cnt++;
          err_cyc = cyc;
          in_frame = 0;
        end
      end
    end
  end

  task automatic send_req(input int sel, input logic [2:0] c, input logic [7:0] h,
                          input logic [31:0] p, output bit ok);
    int n;
    int acc;
    cur = sel;
    cmd = c;
    ch = h;
    pay = p;
    valid[sel] = 1'b1;
    resp_idx = 0;
    n = 0;
    while (!ready[sel] && n < 2000) begin
      step();
      n++;
    end
    if (n >= 2000) check_val("ready_wait_timeout", 32'd0, 32'd1);
    acc = cyc;
    ok = model(c, h, p);
    exp_start_cyc = acc + 1;
    first_pending = ok;
    last_done_cyc = -1;
    step();
    valid = '0;
    cmd = 3'($urandom);
    ch = 8'($urandom);
    pay = $urandom;
    if (ok) begin
      in_frame = 1;
    end else begin
      check_val("reject_err", 32'(etick[sel]), 32'd1);
      check_val("reject_start", 32'(start[sel]), 32'd0);
      check_val("reject_ready", 32'(ready[sel]), 32'd1);
      step();
      check_val("reject_err_clear", 32'(etick[sel]), 32'd0);
      check_val("reject_ready2", 32'(ready[sel]), 32'd1);
    end
  endtask

  task automatic wait_frame();
    int n, d0, e0;
    n = 0;
    d0 = done_cnt;
    e0 = err_cnt;
    while (done_cnt == d0 && err_cnt == e0 && n < 3000) begin
      step();
      n++;
    end
    check_val("frame_done", 32'(done_cnt - d0), 32'd1);
    check_val("frame_err", 32'(err_cnt - e0), 32'd0);
    check_val("frame_bytes_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input int sel);
    check_val("rst_ready", 32'(ready[sel]), 32'd1);
    check_val("rst_start", 32'(start[sel]), 32'd0);
    check_val("rst_busy", 32'(busy[sel]), 32'd0);
    check_val("rst_done", 32'(dtick[sel]), 32'd0);
    check_val("rst_err", 32'(etick[sel]), 32'd0);
    check_val("rst_data", 32'(data[sel]), 32'd0);
  endtask

  initial begin
    bit ok;
    int n, d0, e0;
    rst_n = 1'b0;
    valid = '0;
    spur_drv = '0;
    cmd = '0;
    ch = '0;
    pay = '0;
    repeat (3) step();
    check_reset_vals(0);
    check_reset_vals(1);
    rst_n = 1'b1;
    step();

    // Directed frames, no gap.
    send_req(0, 3'd2, 8'd0, 32'h5555_5555, ok); wait_frame();
    send_req(0, 3'd0, 8'd13, 32'h1234_5678, ok); wait_frame();
    send_req(0, 3'd1, 8'd15, 32'h0000_0005, ok); wait_frame();
    send_req(0, 3'd3, 8'd0, 32'h0000_0514, ok); wait_frame();
    send_req(0, 3'd4, 8'd14, 32'h0000_0002, ok); wait_frame();
    send_req(0, 3'd4, 8'd16, 32'h0000_0002, ok);
    send_req(0, 3'd6, 8'd3, 32'h0000_0000, ok);

    // Randomised commands, including invalid codes and out-of-range channels.
    for (int i = 0; i < 25; i++) begin
      resp_delay = $urandom_range(1, 8);
      send_req(0, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 20)), $urandom, ok);
      if (ok) wait_frame();
    end

    // Gap instance: spurious tick while idle, then frames with a spurious tick in each gap.
    cur = 1;
    step();
    spur_drv[1] = 1'b1;
    step();
    spur_drv = '0;
    check_val("spur_idle_busy", 32'(busy[1]), 32'd0);
    check_val("spur_idle_ready", 32'(ready[1]), 32'd1);
    step();
    check_val("spur_idle_start", 32'(start[1]), 32'd0);
    spur_gap = 1;
    for (int i = 0; i < 5; i++) begin
      resp_delay = $urandom_range(2, 6);
      send_req(1, 3'($urandom_range(0, 4)), 8'($urandom_range(0, 15)), $urandom, ok);
      wait_frame();
    end
    spur_gap = 0;

    // Timeout: byte index 2 never completes.
    resp_delay = 5;
    withhold = 2;
    d0 = done_cnt;
    e0 = err_cnt;
    send_req(0, 3'd0, 8'd7, $urandom, ok);
    n = 0;
    while (err_cnt == e0 && n < 500) begin
      step();
      n++;
    end
    check_val("timeout_err", 32'(err_cnt - e0), 32'd1);
    check_val("timeout_delay", 32'(err_cyc - last_start_cyc), 32'(TO + 1));
    check_val("timeout_no_done", 32'(done_cnt - d0), 32'd0);
    check_val("timeout_bytes_left", 32'(exp_q.size()), 32'd3);
    exp_q.delete();
    withhold = -1;
    step();
    check_val("timeout_ready", 32'(ready[0]), 32'd1);
    check_val("timeout_busy", 32'(busy[0]), 32'd0);

    // Reset in the middle of a frame.
    resp_delay = 10;
    d0 = done_cnt;
    e0 = err_cnt;
    send_req(0, 3'd0, 8'd2, 32'hdead_beef, ok);
    repeat (25) step();
    check_val("pre_rst_busy", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    step();
    check_reset_vals(0);
    exp_q.delete();
    in_frame = 0;
    first_pending = 0;
    rst_n = 1'b1;
    repeat (20) step();
    check_val("post_rst_done", 32'(done_cnt - d0), 32'd0);
    check_val("post_rst_err", 32'(err_cnt - e0), 32'd0);
    check_val("post_rst_ready", 32'(ready[0]), 32'd1);

    // A normal frame still works afterwards.
    send_req(0, 3'd2, 8'd0, 32'ha1b2_c3d4, ok); wait_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
